rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port among NUM_REQ writeback sources (ALU, load unit, CP0/misc).

---
 rtl/regfile_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/rf_wb_arbiter.sv | 62 ++++++
 tb/tb_rf_wb_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: register file widths and constants shared by the writeback path
package regfile_pkg;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int NUM_REGS = 32;
   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, first request at or after ptr (wrapping)
module rr_arbiter #(
   parameter int N = 3,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx
);
   logic [PW-1:0] idx;
   // Scan farthest-first so the candidate nearest ptr is written last and wins
   always_comb begin
      grant = '0;
      grant_idx = '0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = PW'((int'(ptr) + k) % N);
         if (en && req[idx]) begin
            grant = '0;
            grant[idx] = 1'b1;
            grant_idx = idx;
         end
      end
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register file write port among NUM_REQ sources
// RF_WB_BYPASS_EN adds a same-cycle forwarding path for two read ports
module rf_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int DATA_W = regfile_pkg::DATA_W
) (
   input  logic                      clk,
   input  logic                      clrn,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_number,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic                      wb_stall,
   output logic [ADDR_W-1:0]         w_number,
   output logic [DATA_W-1:0]         w_data,
   output logic                      w_en
`ifdef RF_WB_BYPASS_EN
   ,
   input  logic [ADDR_W-1:0]         r_number_a,
   input  logic [ADDR_W-1:0]         r_number_b,
   input  logic [DATA_W-1:0]         rf_data_a,
   input  logic [DATA_W-1:0]         rf_data_b,
   output logic [DATA_W-1:0]         fwd_data_a,
   output logic [DATA_W-1:0]         fwd_data_b
`endif
);
   import regfile_pkg::*;
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   logic [PW-1:0] ptr, grant_idx;
   logic [ADDR_W-1:0] sel_number;
   logic [DATA_W-1:0] sel_data;
   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req(req_valid),
      .ptr(ptr),
      .en(clrn && !wb_stall),
      .grant(req_ready),
      .grant_idx(grant_idx)
   );
   assign sel_number = req_number[int'(grant_idx)*ADDR_W +: ADDR_W];
   assign sel_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];
   // r0 writes are accepted (ready, pointer advance) but never enable the write
   always_ff @(posedge clk) begin
      if (!clrn) begin
         w_en <= 1'b0;
         w_number <= '0;
         w_data <= '0;
         ptr <= '0;
      end else if (|req_ready) begin
         w_en <= sel_number != ADDR_W'(REG_ZERO);
         w_number <= sel_number;
         w_data <= sel_data;
         ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
         w_en <= 1'b0;
      end
   end
`ifdef RF_WB_BYPASS_EN
   assign fwd_data_a = (w_en && w_number == r_number_a && r_number_a != ADDR_W'(REG_ZERO)) ? w_data : rf_data_a;
   assign fwd_data_b = (w_en && w_number == r_number_b && r_number_b != ADDR_W'(REG_ZERO)) ? w_data : rf_data_b;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vector table plus randomized traffic against a grant-order model
module tb_rf_wb_arbiter;
   localparam int N = 3, AW = 5, DW = 32;
   logic clk, clrn, wb_stall, w_en;
   logic [N-1:0] req_valid, req_ready, last_ready;
   logic [N*AW-1:0] req_number;
   logic [N*DW-1:0] req_data;
   logic [AW-1:0] w_number;
   logic [DW-1:0] w_data;
   int checks = 0, errors = 0;
   int m_ptr = 0;
   logic m_en = 0;
   logic [AW-1:0] m_num = 0;
   logic [DW-1:0] m_data = 0;
   int waits[N];
`ifdef RF_WB_BYPASS_EN
   logic [AW-1:0] r_number_a, r_number_b;
   logic [DW-1:0] rf_data_a, rf_data_b, fwd_data_a, fwd_data_b;
`endif

   rf_wb_arbiter #(.NUM_REQ(N)) dut (
      .clk(clk),
      .clrn(clrn),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_number(req_number),
      .req_data(req_data),
      .wb_stall(wb_stall),
      .w_number(w_number),
      .w_data(w_data),
      .w_en(w_en)
`ifdef RF_WB_BYPASS_EN
      ,
      .r_number_a(r_number_a),
      .r_number_b(r_number_b),
      .rf_data_a(rf_data_a),
      .rf_data_b(rf_data_b),
      .fwd_data_a(fwd_data_a),
      .fwd_data_b(fwd_data_b)
`endif
   );

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   typedef struct packed {
      logic c;
      logic s;
      logic [N-1:0] val;
      logic [N-1:0][AW-1:0] num;
      logic [N-1:0][DW-1:0] dat;
      logic [N-1:0] rdy;
      logic en;
      logic [AW-1:0] wn;
      logic [DW-1:0] wd;
   } vec_t;
   vec_t tbl[20];

   function automatic vec_t v(input logic c, input logic s, input logic [2:0] val,
                              input logic [4:0] n0, input logic [4:0] n1, input logic [4:0] n2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [2:0] r, input logic e, input logic [4:0] wn, input logic [31:0] wd);
      vec_t t;
      t.c = c;
      t.s = s;
      t.val = val;
      t.num = {n2, n1, n0};
      t.dat = {d2, d1, d0};
      t.rdy = r;
      t.en = e;
      t.wn = wn;
      t.wd = wd;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Inputs are already applied; check ready, advance the model, then check the registered outputs
   task automatic cyc();
      int g;
      g = -1;
      #1;
      if (clrn && !wb_stall)
         for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      chk("ready", 64'(req_ready), g < 0 ? 64'd0 : 64'd1 << g);
      for (int i = 0; i < N; i++) begin
         if (!clrn || !req_valid[i] || req_ready[i]) waits[i] = 0;
         else if (!wb_stall) begin
            waits[i]++;
            chk("fairness_wait", 64'(waits[i] <= N - 1), 64'd1);
         end
      end
      last_ready = req_ready;
      if (!clrn) begin
         m_en = 0;
         m_num = 0;
         m_data = 0;
         m_ptr = 0;
      end else if (g >= 0) begin
         m_num = req_number[g*AW +: AW];
         m_data = req_data[g*DW +: DW];
         m_en = m_num != 0;
         m_ptr = (g + 1) % N;
      end else begin
         m_en = 0;
      end
      @(posedge clk);
      #1;
      chk("w_en", 64'(w_en), 64'(m_en));
      chk("w_number", 64'(w_number), 64'(m_num));
      chk("w_data", 64'(w_data), 64'(m_data));
   endtask

   initial begin
      clrn = 0;
      wb_stall = 0;
      req_valid = 0;
      req_number = 0;
      req_data = 0;
      last_ready = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
`ifdef RF_WB_BYPASS_EN
      r_number_a = 0;
      r_number_b = 0;
      rf_data_a = 0;
      rf_data_b = 0;
`endif
      tbl[0]  = v(0, 0, 3'b111, 10, 11, 12, 100, 101, 102, 3'b000, 0, 0, 0);
      tbl[1]  = v(1, 0, 3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0, 3'b001, 1, 5, 32'hDEADBEEF);
      tbl[2]  = v(0, 0, 3'b111, 10, 11, 12, 100, 101, 102, 3'b000, 0, 0, 0);
      tbl[3]  = v(1, 0, 3'b111, 10, 11, 12, 100, 101, 102, 3'b001, 1, 10, 100);
      tbl[4]  = v(1, 0, 3'b111, 10, 11, 12, 100, 101, 102, 3'b010, 1, 11, 101);
      tbl[5]  = v(1, 0, 3'b111, 10, 11, 12, 100, 101, 102, 3'b100, 1, 12, 102);
      tbl[6]  = v(1, 0, 3'b111, 10, 11, 12, 100, 101, 102, 3'b001, 1, 10, 100);
      tbl[7]  = v(1, 0, 3'b111, 10, 11, 12, 100, 101, 102, 3'b010, 1, 11, 101);
      tbl[8]  = v(1, 0, 3'b111, 10, 11, 12, 100, 101, 102, 3'b100, 1, 12, 102);
      tbl[9]  = v(1, 1, 3'b111, 10, 11, 12, 100, 101, 102, 3'b000, 0, 12, 102);
      tbl[10] = v(1, 1, 3'b111, 10, 11, 12, 100, 101, 102, 3'b000, 0, 12, 102);
      tbl[11] = v(1, 0, 3'b111, 10, 11, 12, 100, 101, 102, 3'b001, 1, 10, 100);
      tbl[12] = v(1, 0, 3'b010, 10, 0, 12, 100, 1, 102, 3'b010, 0, 0, 1);
      tbl[13] = v(1, 0, 3'b111, 10, 11, 12, 100, 101, 102, 3'b100, 1, 12, 102);
      tbl[14] = v(1, 0, 3'b100, 10, 11, 9, 100, 101, 55, 3'b100, 1, 9, 55);
      tbl[15] = v(0, 0, 3'b111, 10, 11, 12, 100, 101, 102, 3'b000, 0, 0, 0);
      tbl[16] = v(1, 0, 3'b111, 10, 11, 12, 100, 101, 102, 3'b001, 1, 10, 100);
      tbl[17] = v(1, 0, 3'b000, 10, 11, 12, 100, 101, 102, 3'b000, 0, 10, 100);
      tbl[18] = v(1, 0, 3'b001, 3, 11, 12, 7, 101, 102, 3'b001, 1, 3, 7);
      tbl[19] = v(1, 1, 3'b000, 3, 11, 12, 7, 101, 102, 3'b000, 0, 3, 7);
      @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         clrn = tbl[i].c;
         wb_stall = tbl[i].s;
         req_valid = tbl[i].val;
         req_number = tbl[i].num;
         req_data = tbl[i].dat;
         cyc();
         chk($sformatf("v%0d_ready", i), 64'(last_ready), 64'(tbl[i].rdy));
         chk($sformatf("v%0d_w_en", i), 64'(w_en), 64'(tbl[i].en));
         chk($sformatf("v%0d_w_number", i), 64'(w_number), 64'(tbl[i].wn));
         chk($sformatf("v%0d_w_data", i), 64'(w_data), 64'(tbl[i].wd));
      end
`ifdef RF_WB_BYPASS_EN
      req_valid = 3'b001;
      req_number = 15'd7;
      req_data = 96'h1234;
      cyc();
      req_valid = 0;
      r_number_a = 7;
      r_number_b = 0;
      rf_data_a = 32'hAAAA;
      rf_data_b = 32'hBBBB;
      #1;
      chk("fwd_a_hit", 64'(fwd_data_a), 64'h1234);
      chk("fwd_b_r0", 64'(fwd_data_b), 64'hBBBB);
      r_number_a = 8;
      #1;
      chk("fwd_a_miss", 64'(fwd_data_a), 64'hAAAA);
      cyc();
`endif
      clrn = 0;
      cyc();
      for (int c = 0; c < 2000; c++) begin
         clrn = $urandom_range(49) != 0;
         wb_stall = $urandom_range(4) == 0;
         for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && !last_ready[i] && $urandom_range(9) != 0)) begin
               req_valid[i] = $urandom_range(2) != 0;
               req_number[i*AW +: AW] = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
               req_data[i*DW +: DW] = $urandom;
            end
         end
         cyc();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
